// File: rtl/mem_sequencer.sv
// Memory bring-up sequencer: writes addr^seed over a range, reads it back, counts mismatches.
// Per word: 1+HOLD write cycles, then 2+HOLD read/compare cycles; all outputs registered.
module mem_sequencer #(
  parameter int HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] base,
  input  logic [15:0] count,
  input  logic [15:0] seed,
  input  logic [15:0] dataRead,
  output logic [1:0]  control,
  output logic [15:0] addr,
  output logic [15:0] dataWrite,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] errCount,
  output logic [15:0] firstErrAddr
);

  generate
    if (HOLD < 2) begin : g_bad_hold
      $error("mem_sequencer: HOLD must be at least 2");
    end
  endgenerate

  localparam int HW = (HOLD < 2) ? 1 : $clog2(HOLD);

  typedef enum logic [2:0] {
    IDLE, W_SETUP, W_HOLD, R_SETUP, R_HOLD, R_CHECK, DONE
  } state_t;

  state_t        state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [15:0]   remain, remain_nxt;
  logic [15:0]   base_q, base_nxt, count_q, count_nxt, seed_q, seed_nxt;
  logic [15:0]   addr_nxt, dw_nxt, err_nxt, first_nxt, err_upd;
  logic [1:0]    control_nxt;
  logic          done_nxt, pass_nxt, busy_nxt, mismatch;

  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    remain_nxt = remain;
    base_nxt   = base_q;
    count_nxt  = count_q;
    seed_nxt   = seed_q;
    addr_nxt   = addr;
    err_nxt    = errCount;
    first_nxt  = firstErrAddr;
    done_nxt   = done;
    pass_nxt   = pass;
    mismatch   = (dataRead != (addr ^ seed_q));
    err_upd    = (mismatch && errCount != 16'hFFFF) ? errCount + 16'd1 : errCount;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          base_nxt   = base;
          count_nxt  = count;
          seed_nxt   = seed;
          remain_nxt = count;
          addr_nxt   = base;
          err_nxt    = 16'd0;
          first_nxt  = 16'd0;
          // An empty range is trivially clean and finishes at once.
          done_nxt   = (count == 16'd0);
          pass_nxt   = (count == 16'd0);
          state_nxt  = (count == 16'd0) ? DONE : W_SETUP;
        end
      end
      W_SETUP: begin
        hold_nxt  = '0;
        state_nxt = W_HOLD;
      end
      W_HOLD: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_nxt = '0;
          if (remain != 16'd1) begin
            remain_nxt = remain - 16'd1;
            addr_nxt   = addr + 16'd1;
            state_nxt  = W_SETUP;
          end else begin
            remain_nxt = count_q;
            addr_nxt   = base_q;
            state_nxt  = R_SETUP;
          end
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      R_SETUP: begin
        hold_nxt  = '0;
        state_nxt = R_HOLD;
      end
      R_HOLD: begin
        if (hold_cnt == HW'(HOLD - 1)) begin
          hold_nxt  = '0;
          state_nxt = R_CHECK;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      R_CHECK: begin
        err_nxt = err_upd;
        if (mismatch && errCount == 16'd0) first_nxt = addr;
        remain_nxt = remain - 16'd1;
        if (remain != 16'd1) begin
          addr_nxt  = addr + 16'd1;
          state_nxt = R_SETUP;
        end else begin
          done_nxt  = 1'b1;
          pass_nxt  = (err_upd == 16'd0);
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt    = (state_nxt != IDLE) && (state_nxt != DONE);
    control_nxt = (state_nxt == W_HOLD) ? 2'b01 :
                  (state_nxt == R_HOLD) ? 2'b10 : 2'b00;
    // Write data only moves when a new write word is set up.
    dw_nxt      = (state_nxt == W_SETUP) ? (addr_nxt ^ seed_nxt) : dataWrite;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      remain       <= 16'd0;
      base_q       <= 16'd0;
      count_q      <= 16'd0;
      seed_q       <= 16'd0;
      control      <= 2'b00;
      addr         <= 16'd0;
      dataWrite    <= 16'd0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      errCount     <= 16'd0;
      firstErrAddr <= 16'd0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      remain       <= remain_nxt;
      base_q       <= base_nxt;
      count_q      <= count_nxt;
      seed_q       <= seed_nxt;
      control      <= control_nxt;
      addr         <= addr_nxt;
      dataWrite    <= dw_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
      pass         <= pass_nxt;
      errCount     <= err_nxt;
      firstErrAddr <= first_nxt;
    end
  end

endmodule
